voice_mix_scheduler: RTL and testbench

- Sequences sample generation for one codec frame.
- On each generate_next_sample pulse from codec_conditioner, it requests one sample from each enabled voice in turn using a req/ack handshake. It accumulates the signed samples, converts the sum to 18 bits, then drives new_sample_in and pulses latch_new_sample_in back to the conditioner.
- It is the single owner of the conditioner's sample-input side and shares that port among NUM_VOICES note players.

---
 rtl/voice_mix_scheduler.sv | 167 ++++++++++++++++
 tb/tb_voice_mix_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mix_scheduler.sv
// Frame sample sequencer: polls each enabled voice over req/ack, sums the samples and hands
// an 18-bit mix to the codec conditioner. Define MIX_SATURATE_EN to clamp instead of wrap.
module voice_mix_scheduler #(
    parameter int NUM_VOICES     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     generate_next_sample,
    input  logic [NUM_VOICES-1:0]    voice_en,
    output logic [NUM_VOICES-1:0]    voice_req,
    input  logic [NUM_VOICES-1:0]    voice_ack,
    input  logic [18*NUM_VOICES-1:0] voice_sample,
    input  logic                     clear_flags,
    output logic [17:0]              new_sample_in,
    output logic                     latch_new_sample_in,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout
);

    localparam int ACC_W = 18 + $clog2(NUM_VOICES) + 1;
    localparam int IDX_W = $clog2(NUM_VOICES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [17:0]              nsi_q, nsi_d;
    logic                     latch_q, latch_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;

    logic                     sel_en;
    logic                     sel_ack;
    logic signed [17:0]       sel_sample;
    logic [17:0]              mix_out;

    // Mux out the voice addressed by idx; idx==NUM_VOICES selects nothing.
    always_comb begin
        sel_en     = 1'b0;
        sel_ack    = 1'b0;
        sel_sample = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_en     = voice_en[i];
                sel_ack    = voice_ack[i];
                sel_sample = voice_sample[18*i +: 18];
            end
        end
    end

`ifdef MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-131072);

    always_comb begin
        if (acc_q > SAT_MAX) begin
            mix_out = 18'h1FFFF;
        end else if (acc_q < SAT_MIN) begin
            mix_out = 18'h20000;
        end else begin
            mix_out = acc_q[17:0];
        end
    end
`else
    assign mix_out = acc_q[17:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            timer_q   <= '0;
            nsi_q     <= '0;
            latch_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            timer_q   <= timer_d;
            nsi_q     <= nsi_d;
            latch_q   <= latch_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // Flag sets are applied after the clear so a simultaneous set wins.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        timer_d   = timer_q;
        nsi_d     = nsi_q;
        latch_d   = 1'b0;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (clear_flags) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (generate_next_sample) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    nsi_d   = mix_out;
                    latch_d = 1'b1;
                    state_d = IDLE;
                end else if (sel_en) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                if (sel_ack) begin
                    acc_d   = acc_q + {{(ACC_W-18){sel_sample[17]}}, sel_sample};
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCAN;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                    state_d   = SCAN;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (generate_next_sample && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        voice_req = '0;
        if (state_q == WAIT) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_req[i] = (idx_q == IDX_W'(i));
            end
        end
        busy = (state_q != IDLE);
    end

    assign new_sample_in       = nsi_q;
    assign latch_new_sample_in = latch_q;
    assign overrun             = overrun_q;
    assign timeout             = timeout_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Bench for voice_mix_scheduler: two instances (timeout 255 and 4) against a frame-timeline model.
// The model honours MIX_SATURATE_EN the same way the design does.
module tb_voice_mix_scheduler;

    localparam int NV = 3;
    localparam int NI = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              gen;
    logic              clr;
    logic [NV-1:0]     en;
    logic [NV-1:0]     noise;
    logic signed [17:0] smp [NV];
    logic [18*NV-1:0]  vs;
    int                dly [NV];

    logic [NV-1:0]     req [NI];
    logic [17:0]       nsi [NI];
    logic              lat [NI];
    logic              bsy [NI];
    logic              ovr [NI];
    logic              tmo [NI];

    int                ws [NI][NV];
    int                wl [NI][NV];
    int                toc [NI][NV];
    int                latch_c [NI];
    logic [17:0]       exp_new [NI];
    logic [17:0]       prev_nsi [NI];
    bit                f_to [NI];
    bit                f_ov [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign vs = {smp[2], smp[1], smp[0]};

    // Each voice acks once its request has been held for dly cycles; unselected voices see noise.
    for (genvar k = 0; k < NI; k++) begin : g_inst
        logic [NV-1:0] ack_l;
        int            cnt_l [NV];

        voice_mix_scheduler #(
            .NUM_VOICES    (NV),
            .TIMEOUT_CYCLES(k == 0 ? 255 : 4)
        ) dut (
            .clk                 (clk),
            .reset               (reset),
            .generate_next_sample(gen),
            .voice_en            (en),
            .voice_req           (req[k]),
            .voice_ack           (ack_l),
            .voice_sample        (vs),
            .clear_flags         (clr),
            .new_sample_in       (nsi[k]),
            .latch_new_sample_in (lat[k]),
            .busy                (bsy[k]),
            .overrun             (ovr[k]),
            .timeout             (tmo[k])
        );

        always @(posedge clk) begin
            for (int i = 0; i < NV; i++) begin
                cnt_l[i] <= req[k][i] ? cnt_l[i] + 1 : 0;
            end
        end

        always_comb begin
            ack_l = '0;
            for (int i = 0; i < NV; i++) begin
                ack_l[i] = req[k][i] ? (cnt_l[i] >= dly[i]) : noise[i];
            end
        end
    end

    function automatic int timeoutOf(input int k);
        return (k == 0) ? 255 : 4;
    endfunction

    function automatic logic [17:0] conv(input longint s);
        logic [63:0] tmp;
        tmp = s;
`ifdef MIX_SATURATE_EN
        if (s > 131071) return 18'h1FFFF;
        if (s < -131072) return 18'h20000;
`endif
        return tmp[17:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Frame timeline: cycle 1 is the first SCAN; each voice visit is one SCAN cycle plus its WAIT span.
    task automatic computeModel();
        for (int k = 0; k < NI; k++) begin
            int     t;
            int     to;
            longint sum;
            t   = 1;
            sum = 0;
            to  = timeoutOf(k);
            for (int i = 0; i < NV; i++) begin
                ws[k][i]  = -1;
                wl[k][i]  = 0;
                toc[k][i] = -1;
                if (en[i]) begin
                    ws[k][i] = t + 1;
                    if (dly[i] < to) begin
                        wl[k][i] = dly[i] + 1;
                        sum += longint'(smp[i]);
                    end else begin
                        wl[k][i]  = to;
                        toc[k][i] = ws[k][i] + to - 1;
                    end
                    t = ws[k][i] + wl[k][i];
                end else begin
                    t = t + 1;
                end
            end
            latch_c[k] = t + 1;
            exp_new[k] = conv(sum);
        end
    endtask

    task automatic applyStimulus(input string name, input int extra_gen, input int clr_cyc);
        int max_c;
        computeModel();
        max_c = (latch_c[0] > latch_c[1] ? latch_c[0] : latch_c[1]) + 2;
        for (int t = 0; t <= max_c; t++) begin
            @(posedge clk);
            #1;
            gen   = (t == 0) || (t == extra_gen);
            clr   = (t == clr_cyc);
            noise = NV'($urandom);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                logic [NV-1:0] exp_req;
                exp_req = '0;
                for (int i = 0; i < NV; i++) begin
                    if (ws[k][i] >= 0 && t >= ws[k][i] && t < ws[k][i] + wl[k][i]) exp_req[i] = 1'b1;
                end
                checkOutput($sformatf("%s.i%0d.c%0d.req", name, k, t), 32'(req[k]), 32'(exp_req));
                checkOutput($sformatf("%s.i%0d.c%0d.busy", name, k, t), 32'(bsy[k]),
                            32'(t >= 1 && t < latch_c[k]));
                checkOutput($sformatf("%s.i%0d.c%0d.latch", name, k, t), 32'(lat[k]), 32'(t == latch_c[k]));
                checkOutput($sformatf("%s.i%0d.c%0d.sample", name, k, t), 32'(nsi[k]),
                            32'(t >= latch_c[k] ? exp_new[k] : prev_nsi[k]));
                checkOutput($sformatf("%s.i%0d.c%0d.timeout", name, k, t), 32'(tmo[k]), 32'(f_to[k]));
                checkOutput($sformatf("%s.i%0d.c%0d.overrun", name, k, t), 32'(ovr[k]), 32'(f_ov[k]));
            end
            for (int k = 0; k < NI; k++) begin
                if (t == clr_cyc) begin
                    f_to[k] = 1'b0;
                    f_ov[k] = 1'b0;
                end
                for (int i = 0; i < NV; i++) begin
                    if (toc[k][i] == t) f_to[k] = 1'b1;
                end
                if (t == extra_gen && t >= 1 && t < latch_c[k]) f_ov[k] = 1'b1;
            end
        end
        for (int k = 0; k < NI; k++) prev_nsi[k] = exp_new[k];
        gen = 1'b0;
        clr = 1'b0;
    endtask

    task automatic setVoices(input logic [NV-1:0] e, input int d0, input int d1, input int d2,
                             input int s0, input int s1, input int s2);
        en     = e;
        dly[0] = d0;
        dly[1] = d1;
        dly[2] = d2;
        smp[0] = 18'(s0);
        smp[1] = 18'(s1);
        smp[2] = 18'(s2);
    endtask

    task automatic checkQuiet(input string name);
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s.i%0d.req", name, k), 32'(req[k]), 32'(0));
            checkOutput($sformatf("%s.i%0d.busy", name, k), 32'(bsy[k]), 32'(0));
            checkOutput($sformatf("%s.i%0d.latch", name, k), 32'(lat[k]), 32'(0));
            checkOutput($sformatf("%s.i%0d.sample", name, k), 32'(nsi[k]), 32'(0));
            checkOutput($sformatf("%s.i%0d.timeout", name, k), 32'(tmo[k]), 32'(0));
            checkOutput($sformatf("%s.i%0d.overrun", name, k), 32'(ovr[k]), 32'(0));
        end
    endtask

    initial begin
        int latch_seen;
        reset = 1'b0;
        gen   = 1'b0;
        clr   = 1'b0;
        noise = '0;
        setVoices(3'b111, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NI; k++) begin
            prev_nsi[k] = '0;
            f_to[k]     = 1'b0;
            f_ov[k]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkQuiet("por");
        @(posedge clk);
        #1 reset = 1'b1;

        setVoices(3'b111, 0, 0, 0, 1000, -200, 50);
        applyStimulus("basic", -1, -1);
        setVoices(3'b111, 0, 0, 0, 100000, 100000, 100000);
        applyStimulus("bigpos", -1, -1);
        setVoices(3'b111, 0, 0, 0, -100000, -100000, -100000);
        applyStimulus("bigneg", -1, -1);
        setVoices(3'b101, 0, 0, 0, 10, 999, 20);
        applyStimulus("skip1", -1, -1);
        // Voice 1 silent; the clear lands on the short instance's timeout-set cycle.
        setVoices(3'b111, 0, 1000, 0, 5, 777, 7);
        applyStimulus("silent1", -1, 7);
        setVoices(3'b111, 0, 3, 0, -5, 40, 9);
        applyStimulus("lastack", -1, 0);
        setVoices(3'b111, 10, 0, 0, 300, 20, 1);
        applyStimulus("overrun", 5, -1);
        setVoices(3'b000, 0, 0, 0, 11, 22, 33);
        applyStimulus("alloff", -1, 2);

        setVoices(3'b111, 0, 50, 0, 1, 2, 3);
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1 gen = (t == 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        gen = 1'b0;
        @(negedge clk);
        checkQuiet("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        latch_seen = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (lat[k] || bsy[k]) latch_seen++;
            end
        end
        checkOutput("postreset.activity", 32'(latch_seen), 32'(0));
        for (int k = 0; k < NI; k++) begin
            prev_nsi[k] = '0;
            f_to[k]     = 1'b0;
            f_ov[k]     = 1'b0;
        end
        setVoices(3'b111, 0, 0, 0, 1000, -200, 50);
        applyStimulus("afterreset", -1, -1);

        for (int n = 0; n < 12; n++) begin
            int r;
            en = NV'($urandom_range(0, 7));
            for (int i = 0; i < NV; i++) begin
                r      = $urandom_range(0, 9);
                dly[i] = (r >= 8) ? 300 : r;
                smp[i] = 18'($urandom);
            end
            applyStimulus($sformatf("rand%0d", n),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
